// File: rtl/rr_grant_scheduler.sv
// Round-robin arbiter for 2**n requesters driving an n-to-2**n decoder.
// Grants are registered, held until done/withdrawal/timeout, and followed by one dead cycle.
module rr_grant_scheduler #(
  parameter int n        = 2,
  parameter int MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2**n-1:0]   req,
  input  logic              done,
  output logic [2**n-1:0]   gnt,
  output logic [n-1:0]      gnt_idx,
  output logic              gnt_valid,
  output logic              timeout
);

  localparam int N   = 2**n;
  localparam int HCW = $clog2(MAX_HOLD) + 1;
  localparam logic [HCW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HCW'(MAX_HOLD - 1);
  localparam logic [N-1:0]   ONE_HOT0  = N'(1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state, state_nxt;
  logic [n-1:0]   ptr, ptr_nxt;
  logic [n-1:0]   idx_r, idx_nxt;
  logic [N-1:0]   gnt_r, gnt_nxt;
  logic           vld_r, vld_nxt;
  logic           to_r, to_nxt;
  logic [HCW-1:0] hold_cnt, hold_nxt;

  logic [n-1:0]   win, cand;
  logic           win_found;
  logic           rel_done, rel_drop, rel_to, release_now;

  // Scan from ptr upward with natural n-bit wrap; first requester found wins.
  always_comb begin
    win       = ptr;
    win_found = 1'b0;
    cand      = ptr;
    for (int k = 0; k < N; k++) begin
      cand = ptr + n'(k);
      if (!win_found && req[cand]) begin
        win       = cand;
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    rel_done    = done;
    rel_drop    = !req[idx_r];
    rel_to      = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
    release_now = rel_done || rel_drop || rel_to;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      idx_r    <= '0;
      gnt_r    <= '0;
      vld_r    <= 1'b0;
      to_r     <= 1'b0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      idx_r    <= idx_nxt;
      gnt_r    <= gnt_nxt;
      vld_r    <= vld_nxt;
      to_r     <= to_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_found)   state_nxt = GRANT;
      GRANT:   if (release_now) state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // Registered grant datapath; timeout flags only a release caused by the hold limit alone.
  always_comb begin
    ptr_nxt  = ptr;
    idx_nxt  = idx_r;
    gnt_nxt  = gnt_r;
    vld_nxt  = vld_r;
    to_nxt   = 1'b0;
    hold_nxt = hold_cnt;
    case (state)
      IDLE: begin
        if (win_found) begin
          gnt_nxt  = ONE_HOT0 << win;
          idx_nxt  = win;
          vld_nxt  = 1'b1;
          hold_nxt = '0;
        end
      end
      GRANT: begin
        if (release_now) begin
          gnt_nxt = '0;
          vld_nxt = 1'b0;
          ptr_nxt = idx_r + n'(1);
          to_nxt  = rel_to && !rel_done && !rel_drop;
        end else if (MAX_HOLD != 0) begin
          hold_nxt = hold_cnt + HCW'(1);
        end
      end
      default: begin
        gnt_nxt = '0;
        vld_nxt = 1'b0;
      end
    endcase
  end

  always_comb begin
    gnt       = gnt_r;
    gnt_idx   = idx_r;
    gnt_valid = vld_r;
    timeout   = to_r;
  end

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Directed bench for rr_grant_scheduler: n=2 with MAX_HOLD=4, plus a MAX_HOLD=0 instance.
module tb_rr_grant_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, req1;
  logic       done, done1;
  logic [3:0] gnt, gnt1;
  logic [1:0] gnt_idx, gnt_idx1;
  logic       gnt_valid, gnt_valid1;
  logic       timeout, timeout1;

  int n_checks = 0;
  int n_fail   = 0;

  rr_grant_scheduler #(.n(2), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
  );

  rr_grant_scheduler #(.n(2), .MAX_HOLD(0)) dut_nohold (
    .clk(clk), .rst(rst), .req(req1), .done(done1),
    .gnt(gnt1), .gnt_idx(gnt_idx1), .gnt_valid(gnt_valid1), .timeout(timeout1)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; done = 1'b0; req1 = '0; done1 = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({gnt, gnt_idx, gnt_valid, timeout} !== 8'b0) begin
      $display("FAIL reset_outputs: got gnt=%b idx=%0d vld=%b to=%b, want all 0", gnt, gnt_idx, gnt_valid, timeout);
      n_fail++;
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100;
    step();
    n_checks++;
    if (gnt !== 4'b0100 || gnt_idx !== 2'd2 || gnt_valid !== 1'b1) begin
      $display("FAIL single_grant: got gnt=%b idx=%0d vld=%b, want 0100/2/1", gnt, gnt_idx, gnt_valid);
      n_fail++;
    end
    done = 1'b1; req = 4'b0000;
    step();
    done = 1'b0;
    n_checks++;
    if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_idx !== 2'd2 || timeout !== 1'b0) begin
      $display("FAIL single_release: got gnt=%b idx=%0d vld=%b to=%b, want 0000/2/0/0", gnt, gnt_idx, gnt_valid, timeout);
      n_fail++;
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] order [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [3:0] exp;
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      exp = 4'b0001 << order[i];
      n_checks++;
      if (gnt !== exp || gnt_idx !== order[i] || gnt_valid !== 1'b1) begin
        $display("FAIL rr_grant_%0d: got gnt=%b idx=%0d vld=%b, want %b/%0d/1", i, gnt, gnt_idx, gnt_valid, exp, order[i]);
        n_fail++;
      end
      done = 1'b1;
      step();
      done = 1'b0;
      n_checks++;
      if (gnt !== 4'b0000 || gnt_valid !== 1'b0) begin
        $display("FAIL rr_gap_%0d: got gnt=%b vld=%b, want 0000/0", i, gnt, gnt_valid);
        n_fail++;
      end
    end
    req = '0;
  endtask

  task automatic test_timeout();
    do_reset();
    req = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (gnt !== 4'b0010 || timeout !== 1'b0) begin
        $display("FAIL hold_cycle_%0d: got gnt=%b to=%b, want 0010/0", i, gnt, timeout);
        n_fail++;
      end
    end
    step();
    n_checks++;
    if (gnt !== 4'b0000 || timeout !== 1'b1 || gnt_valid !== 1'b0) begin
      $display("FAIL timeout_pulse: got gnt=%b to=%b vld=%b, want 0000/1/0", gnt, timeout, gnt_valid);
      n_fail++;
    end
    step();
    n_checks++;
    if (gnt !== 4'b0010 || gnt_idx !== 2'd1 || timeout !== 1'b0) begin
      $display("FAIL timeout_regrant: got gnt=%b idx=%0d to=%b, want 0010/1/0", gnt, gnt_idx, timeout);
      n_fail++;
    end
    req = '0;
    step();
  endtask

  task automatic test_coincide();
    do_reset();
    req = 4'b0100;
    step();
    step();
    step();
    step();
    done = 1'b1;
    step();
    done = 1'b0;
    req = '0;
    n_checks++;
    if (gnt !== 4'b0000 || timeout !== 1'b0) begin
      $display("FAIL done_with_limit: got gnt=%b to=%b, want 0000/0", gnt, timeout);
      n_fail++;
    end
  endtask

  task automatic test_drop();
    do_reset();
    req = 4'b1000;
    step();
    n_checks++;
    if (gnt !== 4'b1000 || gnt_idx !== 2'd3) begin
      $display("FAIL drop_grant3: got gnt=%b idx=%0d, want 1000/3", gnt, gnt_idx);
      n_fail++;
    end
    req = 4'b0001;
    step();
    n_checks++;
    if (gnt !== 4'b0000 || timeout !== 1'b0 || gnt_valid !== 1'b0) begin
      $display("FAIL drop_release: got gnt=%b to=%b vld=%b, want 0000/0/0", gnt, timeout, gnt_valid);
      n_fail++;
    end
    step();
    n_checks++;
    if (gnt !== 4'b0001 || gnt_idx !== 2'd0) begin
      $display("FAIL drop_wrap: got gnt=%b idx=%0d, want 0001/0", gnt, gnt_idx);
      n_fail++;
    end
    req = '0;
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b0010;
    step();
    req = '0;
    step();
    req = 4'b1000;
    step();
    n_checks++;
    if (gnt !== 4'b1000) begin
      $display("FAIL mid_pre: got gnt=%b, want 1000", gnt);
      n_fail++;
    end
    rst = 1'b1; req = 4'b1001;
    step();
    rst = 1'b0;
    n_checks++;
    if ({gnt, gnt_idx, gnt_valid, timeout} !== 8'b0) begin
      $display("FAIL mid_reset: got gnt=%b idx=%0d vld=%b to=%b, want all 0", gnt, gnt_idx, gnt_valid, timeout);
      n_fail++;
    end
    step();
    n_checks++;
    if (gnt !== 4'b0001 || gnt_idx !== 2'd0) begin
      $display("FAIL mid_first: got gnt=%b idx=%0d, want 0001/0", gnt, gnt_idx);
      n_fail++;
    end
    req = '0;
    step();
  endtask

  task automatic test_idle_done();
    do_reset();
    done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
        $display("FAIL idle_done_%0d: got gnt=%b vld=%b to=%b, want 0000/0/0", i, gnt, gnt_valid, timeout);
        n_fail++;
      end
    end
    done = 1'b0;
    req = 4'b0010;
    step();
    n_checks++;
    if (gnt !== 4'b0010 || gnt_idx !== 2'd1) begin
      $display("FAIL idle_done_after: got gnt=%b idx=%0d, want 0010/1", gnt, gnt_idx);
      n_fail++;
    end
    req = '0;
    step();
  endtask

  task automatic test_no_timeout();
    do_reset();
    req1 = 4'b0010;
    step();
    for (int i = 0; i < 100; i++) begin
      step();
      n_checks++;
      if (gnt1 !== 4'b0010 || timeout1 !== 1'b0 || gnt_valid1 !== 1'b1) begin
        $display("FAIL nohold_cycle_%0d: got gnt=%b to=%b vld=%b, want 0010/0/1", i, gnt1, timeout1, gnt_valid1);
        n_fail++;
      end
    end
    req1 = '0;
    step();
    n_checks++;
    if (gnt1 !== 4'b0000 || timeout1 !== 1'b0) begin
      $display("FAIL nohold_release: got gnt=%b to=%b, want 0000/0", gnt1, timeout1);
      n_fail++;
    end
  endtask

  initial begin
    rst = 1'b1; req = '0; done = 1'b0; req1 = '0; done1 = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_coincide();
    test_drop();
    test_reset_mid();
    test_idle_done();
    test_no_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
